// File: rtl/conv_pkg.sv
// Shared types and layout helpers for the multi-channel convolution engine:
// pipeline tag, tap count, reduction depth, and window/weight/bias bit offsets.
package conv_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic bias_en;
  } tag_t;

  function automatic int unsigned taps_of(input int unsigned k);
    return k * k;
  endfunction

  function automatic int unsigned tree_depth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Window taps are stored MSB-first: tap 0 occupies the top slice.
  function automatic int unsigned win_lsb(input int unsigned taps, input int unsigned dw,
                                          input int unsigned t);
    return (taps - 1 - t) * dw;
  endfunction

  function automatic int unsigned wt_lsb(input int unsigned taps, input int unsigned ww,
                                         input int unsigned f, input int unsigned t);
    return (f * taps + t) * ww;
  endfunction

  function automatic int unsigned bias_lsb(input int unsigned ow, input int unsigned f);
    return f * ow;
  endfunction

endpackage

// File: rtl/conv_dot_product.sv
// One filter's dot product: registered per-tap products (S1) followed by a
// registered reduction of all taps (S2); both stages hold while en_i is low.
module conv_dot_product
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned OUTPUT_WIDTH = 32,
  localparam int unsigned TAPS        = taps_of(KERNEL_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_i,
  input  logic                           signed_i,
  input  logic [TAPS*DATA_WIDTH-1:0]     win_i,
  input  logic [TAPS*WEIGHT_WIDTH-1:0]   wt_i,
  output logic [OUTPUT_WIDTH-1:0]        sum_o
);

  localparam int unsigned PW = DATA_WIDTH + WEIGHT_WIDTH + 1;

  logic [OUTPUT_WIDTH-1:0] prod_d [TAPS];
  logic [OUTPUT_WIDTH-1:0] prod_q [TAPS];
  logic [OUTPUT_WIDTH-1:0] sum_d;
  logic [OUTPUT_WIDTH-1:0] sum_q;

  // Activation widened by one bit so unsigned values keep their magnitude.
  function automatic logic [OUTPUT_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0]   a,
                                                  input logic [WEIGHT_WIDTH-1:0] w,
                                                  input logic                    sgn);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] wx;
    ax = sgn ? PW'($signed(a)) : PW'($signed({1'b0, a}));
    wx = PW'($signed(w));
    return OUTPUT_WIDTH'(ax * wx);
  endfunction

  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      prod_d[t] = mul(win_i[win_lsb(TAPS, DATA_WIDTH, t) +: DATA_WIDTH],
                      wt_i[t*WEIGHT_WIDTH +: WEIGHT_WIDTH], signed_i);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int t = 0; t < TAPS; t++) begin
      sum_d = sum_d + prod_q[t];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) prod_q[t] <= '0;
      sum_q <= '0;
    end else if (en_i) begin
      for (int t = 0; t < TAPS; t++) prod_q[t] <= prod_d[t];
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/conv_systolic_mc.sv
// Streaming multi-channel, multi-filter KxK convolution: weight bank, channel
// counter, cross-channel accumulation and handshakes. Optional ReLU: CONV_RELU_EN.
module conv_systolic_mc
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned NUM_FILTERS  = 2,
  parameter int unsigned IN_CHANNELS  = 2,
  localparam int unsigned TAPS        = taps_of(KERNEL_SIZE),
  localparam int unsigned CH_W        = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cfg_signed,
  input  logic                                       wt_valid,
  output logic                                       wt_ready,
  input  logic [CH_W-1:0]                            wt_channel,
  input  logic [NUM_FILTERS*TAPS*WEIGHT_WIDTH-1:0]   wt_data,
  input  logic                                       win_valid,
  output logic                                       win_ready,
  input  logic [TAPS*DATA_WIDTH-1:0]                 win_data,
  input  logic [NUM_FILTERS*OUTPUT_WIDTH-1:0]        bias,
  input  logic                                       bias_en,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [NUM_FILTERS*OUTPUT_WIDTH-1:0]        out_data,
  output logic                                       busy
);

  localparam int unsigned OW = OUTPUT_WIDTH;
  localparam int unsigned WW = WEIGHT_WIDTH;

  logic [WW-1:0]        wt_q   [NUM_FILTERS][IN_CHANNELS][TAPS];
  logic [TAPS*WW-1:0]   wsel   [NUM_FILTERS];
  logic [OW-1:0]        sum    [NUM_FILTERS];
  logic [OW-1:0]        acc_q  [NUM_FILTERS];
  logic [OW-1:0]        acc_d  [NUM_FILTERS];
  logic [OW-1:0]        res_d  [NUM_FILTERS];
  logic [OW-1:0]        out_q  [NUM_FILTERS];
  logic [CH_W-1:0]      ch_cnt_q;
  logic [CH_W-1:0]      ch_cnt_d;
  tag_t                 s1_q, s1_d, s2_q;
  logic                 out_valid_q;
  logic                 adv, wt_fire, win_fire, last_c;

  // Handshakes: weights load only into an idle engine, and a load blocks windows.
  assign adv       = !out_valid_q || out_ready;
  assign wt_ready  = !rst && (ch_cnt_q == '0) && !s1_q.valid && !s2_q.valid && !out_valid_q;
  assign wt_fire   = wt_valid && wt_ready;
  assign win_ready = !rst && adv && !wt_fire;
  assign win_fire  = win_valid && win_ready;
  assign last_c    = (ch_cnt_q == CH_W'(IN_CHANNELS - 1));
  assign ch_cnt_d  = last_c ? '0 : ch_cnt_q + CH_W'(1);
  assign busy      = (ch_cnt_q != '0) || s1_q.valid || s2_q.valid || out_valid_q;
  assign out_valid = out_valid_q;

  always_comb begin
    s1_d.valid   = win_fire;
    s1_d.first   = (ch_cnt_q == '0);
    s1_d.last    = last_c;
    s1_d.bias_en = bias_en;
  end

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      wsel[f] = '0;
      for (int t = 0; t < TAPS; t++) begin
        wsel[f][t*WW +: WW] = wt_q[f][ch_cnt_q][t];
      end
    end
  end

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filt
    conv_dot_product #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .KERNEL_SIZE  (KERNEL_SIZE),
      .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_dot (
      .clk      (clk),
      .rst      (rst),
      .en_i     (adv),
      .signed_i (cfg_signed),
      .win_i    (win_data),
      .wt_i     (wsel[f]),
      .sum_o    (sum[f])
    );
    assign out_data[f*OW +: OW] = out_q[f];
  end

  // S3: cross-channel accumulation, bias on the final channel, optional ReLU.
  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      acc_d[f] = (s2_q.first ? '0 : acc_q[f]) + sum[f];
      res_d[f] = acc_d[f] + (s2_q.bias_en ? bias[bias_lsb(OW, f) +: OW] : '0);
`ifdef CONV_RELU_EN
      if (res_d[f][OW-1]) res_d[f] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        for (int c = 0; c < IN_CHANNELS; c++) begin
          for (int t = 0; t < TAPS; t++) wt_q[f][c][t] <= '0;
        end
        acc_q[f] <= '0;
        out_q[f] <= '0;
      end
      ch_cnt_q    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wt_fire) begin
        for (int c = 0; c < IN_CHANNELS; c++) begin
          if (wt_channel == CH_W'(c)) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
              for (int t = 0; t < TAPS; t++) begin
                wt_q[f][c][t] <= wt_data[wt_lsb(TAPS, WW, f, t) +: WW];
              end
            end
          end
        end
      end
      if (win_fire) ch_cnt_q <= ch_cnt_d;
      if (adv) begin
        s1_q        <= s1_d;
        s2_q        <= s1_q;
        out_valid_q <= s2_q.valid && s2_q.last;
        for (int f = 0; f < NUM_FILTERS; f++) begin
          if (s2_q.valid) acc_q[f] <= acc_d[f];
          if (s2_q.valid && s2_q.last) out_q[f] <= res_d[f];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_systolic_mc.sv
// Randomized self-checking bench for conv_systolic_mc against a frame-level
// arithmetic model (weights per channel, per-frame accumulation, bias, ReLU).
module tb_conv_systolic_mc;

  localparam int DW   = 8;
  localparam int WW   = 8;
  localparam int K    = 3;
  localparam int TAPS = K * K;
  localparam int OW   = 32;
  localparam int NF   = 2;
  localparam int IC   = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cfg_signed = 1'b0;
  logic                   wt_valid = 1'b0;
  logic                   wt_ready;
  logic [0:0]             wt_channel = '0;
  logic [NF*TAPS*WW-1:0]  wt_data = '0;
  logic                   win_valid = 1'b0;
  logic                   win_ready;
  logic [TAPS*DW-1:0]     win_data = '0;
  logic [NF*OW-1:0]       bias = '0;
  logic                   bias_en = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [NF*OW-1:0]       out_data;
  logic                   busy;

  always #5 clk = ~clk;

  conv_systolic_mc #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .KERNEL_SIZE(K),
    .OUTPUT_WIDTH(OW), .NUM_FILTERS(NF), .IN_CHANNELS(IC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_signed(cfg_signed),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_channel(wt_channel), .wt_data(wt_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .bias(bias), .bias_en(bias_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Reference model: weights per filter/channel, running frame sums, result queue.
  int mw [NF][IC][TAPS];
  int macc [NF];
  int mch = 0;
  int exp_q [$];
  int out_cnt = 0;
  int last_res [NF];
  int m_dot, m_av, m_r, m_e;
  logic [DW-1:0] m_a;

  always @(posedge clk) begin
    if (rst) begin
      mch = 0;
      exp_q.delete();
      for (int f = 0; f < NF; f++) begin
        macc[f] = 0;
        for (int c = 0; c < IC; c++)
          for (int t = 0; t < TAPS; t++) mw[f][c][t] = 0;
      end
    end else begin
      if (wt_valid && wt_ready) begin
        for (int f = 0; f < NF; f++)
          for (int t = 0; t < TAPS; t++)
            mw[f][wt_channel][t] = int'($signed(wt_data[(f*TAPS+t)*WW +: WW]));
      end
      if (win_valid && win_ready) begin
        for (int f = 0; f < NF; f++) begin
          m_dot = 0;
          for (int t = 0; t < TAPS; t++) begin
            m_a   = win_data[(TAPS-1-t)*DW +: DW];
            m_av  = cfg_signed ? int'($signed(m_a)) : int'(m_a);
            m_dot = m_dot + m_av * mw[f][mch][t];
          end
          macc[f] = ((mch == 0) ? 0 : macc[f]) + m_dot;
        end
        if (mch == IC - 1) begin
          for (int f = 0; f < NF; f++) begin
            m_r = macc[f] + (bias_en ? int'(bias[f*OW +: OW]) : 0);
`ifdef CONV_RELU_EN
            if (m_r < 0) m_r = 0;
`endif
            exp_q.push_back(m_r);
          end
          mch = 0;
        end else begin
          mch = mch + 1;
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        for (int f = 0; f < NF; f++) begin
          if (exp_q.size() > 0) m_e = exp_q.pop_front();
          else m_e = 32'hDEADBEEF;
          chk($sformatf("out_f%0d_#%0d", f, out_cnt), out_data[f*OW +: OW], m_e);
          last_res[f] = int'(out_data[f*OW +: OW]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NF*TAPS*WW-1:0] pack_wt(input int a[TAPS], input int b[TAPS]);
    logic [NF*TAPS*WW-1:0] r;
    r = '0;
    for (int t = 0; t < TAPS; t++) begin
      r[t*WW +: WW]        = 8'(a[t]);
      r[(TAPS+t)*WW +: WW] = 8'(b[t]);
    end
    return r;
  endfunction

  function automatic logic [TAPS*DW-1:0] rnd_win();
    return (TAPS*DW)'({$urandom, $urandom, $urandom});
  endfunction

  function automatic logic [NF*TAPS*WW-1:0] rnd_wt();
    return (NF*TAPS*WW)'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic load_wt(input int ch, input logic [NF*TAPS*WW-1:0] d);
    int b;
    b = 0;
    wt_valid = 1'b1; wt_channel = 1'(ch); wt_data = d;
    #1;
    while (!wt_ready && b < 50) begin tick(); b++; end
    chk("wt_ready_seen", 32'(wt_ready), 1);
    tick();
    wt_valid = 1'b0;
  endtask

  task automatic send_win(input logic [TAPS*DW-1:0] d, input logic be);
    int b;
    b = 0;
    win_valid = 1'b1; win_data = d; bias_en = be;
    #1;
    while (!win_ready && b < 50) begin tick(); b++; end
    chk("win_ready_seen", 32'(win_ready), 1);
    tick();
    win_valid = 1'b0;
  endtask

  task automatic wait_out(input int c0);
    int b;
    b = 0;
    while (out_cnt <= c0 && b < 100) begin tick(); b++; end
    chk("result_seen", 32'(out_cnt > c0), 1);
  endtask

  task automatic frame(input logic [TAPS*DW-1:0] d, input logic be, input int e0, input int e1,
                       input string tag);
    int c0;
    c0 = out_cnt;
    send_win(d, be);
    send_win(d, be);
    wait_out(c0);
    chk({tag, "_f0"}, last_res[0], e0);
    chk({tag, "_f1"}, last_res[1], e1);
  endtask

  task automatic stream(input int n, input bit rnd_rdy, output int cycles);
    int sent;
    int b;
    bit f;
    sent = 0; b = 0; cycles = 0;
    win_valid = 1'b1; win_data = rnd_win(); bias_en = 1'($urandom_range(0, 1));
    while (sent < n && b < 20 * n) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      f = win_ready;
      tick();
      cycles++; b++;
      if (f) begin
        sent++;
        win_data = rnd_win();
        bias_en  = 1'($urandom_range(0, 1));
      end
    end
    win_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, n);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 300) begin tick(); b++; end
    chk("idle", 32'(busy), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  int lap  [TAPS] = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
  int ones [TAPS] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [TAPS*DW-1:0] win123;
  logic [TAPS*DW-1:0] win_ff;
  logic [NF*OW-1:0]   held;
  int cyc_n, c0;

  initial begin
    for (int t = 0; t < TAPS; t++) win123[(TAPS-1-t)*DW +: DW] = 8'(t + 1);
    win_ff = '1;

    // Reset state
    tick();
    chk("rst_win_ready", 32'(win_ready), 0);
    chk("rst_wt_ready", 32'(wt_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data_lo", out_data[31:0], 0);
    chk("rst_out_data_hi", out_data[63:32], 0);
    chk("rst_busy", 32'(busy), 0);

    // Basic frame with latency check
    load_wt(0, pack_wt(lap, ones));
    load_wt(1, pack_wt(lap, ones));
    c0 = out_cnt;
    send_win(win123, 1'b0);
    send_win(win123, 1'b0);
    tick();
    chk("latency_n2_low", 32'(out_valid), 0);
    tick();
    chk("latency_n3_high", 32'(out_valid), 1);
    chk("basic_f0", out_data[31:0], 0);
    chk("basic_f1", out_data[63:32], 90);
    wait_out(c0);

    // Bias
    bias = {32'd0, 32'd10};
    frame(win123, 1'b1, 10, 90, "bias");

    // Signedness
    bias = '0;
    cfg_signed = 1'b0;
    frame(win_ff, 1'b0, 0, 4590, "unsigned");
    wait_idle();
    cfg_signed = 1'b1;
`ifdef CONV_RELU_EN
    frame(win_ff, 1'b0, 0, 0, "signed");
`else
    frame(win_ff, 1'b0, 0, -18, "signed");
`endif
    wait_idle();

    // Streaming with random weights, bias and signedness
    load_wt(0, rnd_wt());
    load_wt(1, rnd_wt());
    bias = {$urandom, $urandom};
    cfg_signed = 1'($urandom_range(0, 1));
    c0 = out_cnt;
    stream(100, 1'b0, cyc_n);
    chk("stream_cycles", cyc_n, 100);
    repeat (4) tick();
    chk("stream_results", out_cnt - c0, 50);

    // Backpressure: stall output for 5 cycles
    stream(6, 1'b0, cyc_n);
    out_ready = 1'b0;
    win_valid = 1'b1; win_data = rnd_win();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("stall_out_valid", 32'(out_valid), 1);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_win_ready", 32'(win_ready), 0);
      chk("stall_data_lo", out_data[31:0], held[31:0]);
      chk("stall_data_hi", out_data[63:32], held[63:32]);
    end
    out_ready = 1'b1;
    stream(10, 1'b0, cyc_n);
    if (mch != 0) send_win(rnd_win(), 1'b0);
    wait_idle();

    // Random output backpressure
    stream(40, 1'b1, cyc_n);
    wait_idle();

    // Load guard, mid-frame reset, weights cleared
    bias = '0;
    cfg_signed = 1'b0;
    send_win(win123, 1'b0);
    wt_valid = 1'b1; wt_channel = 1'b0; wt_data = rnd_wt();
    #1;
    chk("guard_wt_ready", 32'(wt_ready), 0);
    chk("guard_win_ready", 32'(win_ready), 1);
    chk("guard_busy", 32'(busy), 1);
    wt_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    frame(win123, 1'b0, 0, 0, "zero_weights");
    wait_idle();

    // Reload and rerun the basic frame
    load_wt(0, pack_wt(lap, ones));
    load_wt(1, pack_wt(lap, ones));
    frame(win123, 1'b0, 0, 90, "reload");
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
